// File: rtl/lif_pkg.sv
// Shared constants and saturating arithmetic helpers for the LIF layer.
package lif_pkg;

    localparam int unsigned DEF_N_IN        = 3;
    localparam int unsigned DEF_W           = 8;
    localparam int unsigned DEF_THRESH      = 200;
    localparam int unsigned DEF_LEAK_SHIFT  = 3;
    localparam int unsigned DEF_REFRAC      = 2;
    localparam int unsigned DEF_WEIGHT_INIT = 64;
    localparam int unsigned CNT_W           = 16;
    localparam int unsigned CALC_W          = 32;

    // Membrane after one cycle of exponential decay.
    function automatic logic [CALC_W-1:0] leak(input logic [CALC_W-1:0] s,
                                               input int unsigned shift);
        return s - (s >> shift);
    endfunction

    // a + b clamped to the largest unsigned value of the given width.
    function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] b,
                                                  input int unsigned width);
        logic [CALC_W:0] sum;
        logic [CALC_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((CALC_W+1)'(1) << width) - (CALC_W+1)'(1);
        return (sum > lim) ? lim[CALC_W-1:0] : sum[CALC_W-1:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Single leaky-integrate-and-fire neuron with refractory hold and saturating integration.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int unsigned W          = DEF_W,
    parameter int unsigned THRESH     = DEF_THRESH,
    parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC     = DEF_REFRAC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] current,
    output logic [W-1:0] state,
    output logic         spike
);

    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [RW-1:0]     refr;
    logic [CALC_W-1:0] v_c;

    always_comb begin
        v_c = sat_add(leak(CALC_W'(state), LEAK_SHIFT), CALC_W'(current), W);
    end

    // While refractory the membrane is pinned to zero and the input is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
            refr  <= '0;
            spike <= 1'b0;
        end else if (refr != '0) begin
            state <= '0;
            refr  <= refr - RW'(1);
            spike <= 1'b0;
        end else if (v_c >= CALC_W'(THRESH)) begin
            state <= '0;
            refr  <= RW'(REFRAC);
            spike <= 1'b1;
        end else begin
            state <= W'(v_c);
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/lif_layer_network.sv
// LIF layer: N_IN input neurons feeding one output neuron through programmable weights.
module lif_layer_network
    import lif_pkg::*;
#(
    parameter int unsigned N_IN        = DEF_N_IN,
    parameter int unsigned W           = DEF_W,
    parameter int unsigned THRESH      = DEF_THRESH,
    parameter int unsigned LEAK_SHIFT  = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC      = DEF_REFRAC,
    parameter int unsigned WEIGHT_INIT = DEF_WEIGHT_INIT,
    localparam int unsigned AW         = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN*W-1:0] ext_current,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              cnt_clr,
    output logic [N_IN-1:0]   spike_in,
    output logic              spike_output,
    output logic [W-1:0]      state,
    output logic [CNT_W-1:0]  spike_count
);

    localparam int unsigned SW    = W + $clog2(N_IN) + 1;
    localparam logic [W-1:0] W_MAX = '1;

    logic [W-1:0]  weight [N_IN];
    logic [W-1:0]  cur_out;
    logic [SW-1:0] sum_c;
    logic [W-1:0]  cur_next_c;
    logic [W-1:0]  in_state_unused [N_IN];

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        lif_neuron_core #(
            .W(W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
        ) u_core (
            .clk     (clk),
            .reset   (reset),
            .current (ext_current[g*W +: W]),
            .state   (in_state_unused[g]),
            .spike   (spike_in[g])
        );
    end

    lif_neuron_core #(
        .W(W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) u_out (
        .clk     (clk),
        .reset   (reset),
        .current (cur_out),
        .state   (state),
        .spike   (spike_output)
    );

    // Weighted spike sum, wide enough to never wrap, then clamped to W bits.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                sum_c = sum_c + SW'(weight[i]);
            end
        end
        cur_next_c = (sum_c > SW'(W_MAX)) ? W_MAX : sum_c[W-1:0];
    end

    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                weight[i] <= W'(WEIGHT_INIT);
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (wr_en && (32'(wr_addr) == i)) begin
                    weight[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_out <= '0;
        end else begin
            cur_out <= cur_next_c;
        end
    end

    // Clear wins over counting; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spike_count <= '0;
        end else if (cnt_clr) begin
            spike_count <= '0;
        end else if (spike_output && (spike_count != '1)) begin
            spike_count <= spike_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lif_layer_network.sv
// Scoreboard bench for lif_layer_network: stimulus queues expected spikes and probes, a monitor checks them.
module tb_lif_layer_network;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] ext_current;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        cnt_clr;
    logic [2:0]  spike_in;
    logic        spike_output;
    logic [7:0]  state;
    logic [15:0] spike_count;

    lif_layer_network u_dut (
        .clk          (clk),
        .reset        (reset),
        .ext_current  (ext_current),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cnt_clr      (cnt_clr),
        .spike_in     (spike_in),
        .spike_output (spike_output),
        .state        (state),
        .spike_count  (spike_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  sin;
        logic        sout;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        bit          is_cnt;
        logic [15:0] val;
    } probe_t;

    ev_t         ev_q[$];
    probe_t      pr_q[$];
    int unsigned cyc = 0;
    int unsigned base = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ev(input int unsigned off, input logic [2:0] si, input logic so);
        ev_q.push_back('{base + off, si, so});
    endtask

    task automatic st(input int unsigned off, input logic [15:0] v);
        pr_q.push_back('{base + off, 1'b0, v});
    endtask

    task automatic cn(input int unsigned off, input logic [15:0] v);
        pr_q.push_back('{base + off, 1'b1, v});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks outputs cleared at once, releases on the next negedge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset       = 1'b0;
        ext_current = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        cnt_clr     = 1'b0;
        #1;
        chk("rst_spike_in", 32'(spike_in), 32'd0);
        chk("rst_spike_output", 32'(spike_output), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_spike_count", 32'(spike_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        base  = cyc;
    endtask

    // Monitor: spike activity pops the event queue; timed probes check state/count.
    always @(negedge clk) begin
        if (spike_in != 3'b000 || spike_output) begin
            if (ev_q.size() == 0) begin
                chk("ev_unexpected", 32'({spike_in, spike_output}), 32'd0);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk($sformatf("ev_spike_in@%0d", e.cyc), 32'(spike_in), 32'(e.sin));
                chk($sformatf("ev_spike_out@%0d", e.cyc), 32'(spike_output), 32'(e.sout));
            end
        end
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            chk("ev_missed", cyc, ev_q[0].cyc);
            void'(ev_q.pop_front());
        end
        while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
            probe_t p;
            p = pr_q.pop_front();
            if (p.cyc != cyc) begin
                chk("probe_missed", cyc, p.cyc);
            end else if (p.is_cnt) begin
                chk($sformatf("spike_count@%0d", p.cyc), 32'(spike_count), 32'(p.val));
            end else begin
                chk($sformatf("state@%0d", p.cyc), 32'(state), 32'(p.val));
            end
        end
    end

    initial begin
        reset = 1'b0; ext_current = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cnt_clr = 1'b0;

        // Leak and threshold: 100, 188, 255 -> spike, two refractory cycles, fire again.
        apply_reset();
        ext_current = 24'd100;
        ev(3, 3'b001, 1'b0);
        st(3, 0); st(4, 0); st(5, 64); st(6, 56);
        ev(8, 3'b001, 1'b0);
        st(10, 98);
        tick(8);
        ext_current = '0;
        tick(4);

        // Two inputs firing every 3 cycles drive the output neuron over threshold.
        apply_reset();
        ext_current = 24'h00FFFF;
        ev(1, 3'b011, 1'b0);
        st(3, 128); st(4, 112);
        ev(4, 3'b011, 1'b0);
        ev(6, 3'b000, 1'b1);
        st(6, 0); cn(6, 0); cn(7, 1);
        ev(7, 3'b011, 1'b0);
        st(9, 128);
        tick(7);
        ext_current = '0;
        tick(4);

        // Weight saturation: 3x255 and 2x150 both clamp to 255.
        apply_reset();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd255;
        tick(1); wr_addr = 2'd1;
        tick(1); wr_addr = 2'd2;
        tick(1); wr_en = 1'b0;
        base = cyc;
        ext_current = 24'hFFFFFF;
        ev(1, 3'b111, 1'b0);
        ev(3, 3'b000, 1'b1);
        st(3, 0);
        tick(1); ext_current = '0;
        tick(2);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd150;
        tick(1); wr_addr = 2'd1;
        tick(1); wr_en = 1'b0;
        base = cyc;
        ext_current = 24'h00FFFF;
        ev(1, 3'b011, 1'b0);
        ev(3, 3'b000, 1'b1);
        cn(4, 2);
        tick(1); ext_current = '0;
        tick(4);

        // Write collision uses the old weight; write to address 3 is dropped.
        apply_reset();
        ext_current = 24'h00FF00;
        ev(1, 3'b010, 1'b0);
        st(2, 0); st(3, 64);
        ev(4, 3'b111, 1'b0);
        st(6, 181);
        tick(1);
        ext_current = '0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'd10;
        tick(1);
        wr_addr = 2'd3; wr_data = 8'd0;
        tick(1);
        wr_en = 1'b0; ext_current = 24'hFFFFFF;
        tick(1);
        ext_current = '0;
        tick(4);

        // Counter saturates at FFFF; clear beats a simultaneous spike.
        apply_reset();
        ext_current = 24'h00FFFF;
        #2 force u_dut.spike_count = 16'hFFFE;
        #1 release u_dut.spike_count;
        ev(1, 3'b011, 1'b0); ev(4, 3'b011, 1'b0); ev(6, 3'b000, 1'b1);
        ev(7, 3'b011, 1'b0); ev(10, 3'b011, 1'b0); ev(12, 3'b000, 1'b1);
        ev(13, 3'b011, 1'b0); ev(16, 3'b011, 1'b0); ev(18, 3'b000, 1'b1);
        cn(6, 16'hFFFE); cn(7, 16'hFFFF); cn(12, 16'hFFFF); cn(13, 16'hFFFF);
        cn(19, 0); cn(20, 0);
        tick(18);
        cnt_clr = 1'b1; ext_current = '0;
        tick(1);
        cnt_clr = 1'b0;
        tick(3);

        // Reset while neuron 2 is refractory and cur_out is nonzero.
        apply_reset();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd20;
        ext_current = 24'hFF0000;
        ev(1, 3'b100, 1'b0);
        st(3, 20); st(4, 18);
        ev(4, 3'b100, 1'b0);
        st(5, 16);
        tick(1);
        wr_en = 1'b0;
        tick(3);
        apply_reset();
        ext_current = 24'hFF0000;
        ev(1, 3'b100, 1'b0);
        st(3, 64);
        tick(1);
        ext_current = '0;
        tick(5);

        chk("ev_q_drained", 32'(ev_q.size()), 32'd0);
        chk("pr_q_drained", 32'(pr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lif_layer_network.md
# lif_layer_network

Parametrised leaky-integrate-and-fire layer: N_IN input neurons with configurable width, leak, threshold and refractory period, all feeding one output neuron through run-time programmable synaptic weights. It is the generalised successor of the fixed three-input spiking network and sits between the external current inputs and the spike observation logic. Unlike the fixed network, it adds exponential leak, a refractory period, saturating arithmetic, weight programming and an output spike counter.

## Interface
- N_IN, 3: number of input neurons (≥1)
- W, 8: membrane, current and weight width in bits
- THRESH, 200: firing threshold (1 … 2^W−1)
- LEAK_SHIFT, 3: leak per cycle = state >> LEAK_SHIFT (0 = full leak to the input value each cycle)
- REFRAC, 2: refractory cycles after a spike (0 = none)
- WEIGHT_INIT, 64: reset value of every weight
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ext_current  in  N_IN*W  packed input currents; neuron i uses bits [i*W +: W]
- wr_en  in  1  weight write strobe
- wr_addr  in  max(1,$clog2(N_IN))  weight index
- wr_data  in  W  new weight value
- cnt_clr  in  1  synchronous clear of the spike counter
- spike_in  out  N_IN  registered spikes of the input neurons
- spike_output  out  1  registered spike of the output neuron
- state  out  W  membrane state of the output neuron
- spike_count  out  16  saturating count of output-neuron spikes

## Operation
- Every neuron (input and output) holds membrane s (W bits) and refractory counter r (width $clog2(REFRAC+1), minimum 1). Per edge:
  - if r≠0: s←0, r←r−1, spike←0; the input current is ignored.
  - else v = sat(s − (s>>LEAK_SHIFT) + current), computed W+1 bits wide and clamped to 2^W−1. If v ≥ THRESH: spike←1, s←0, r←REFRAC. Otherwise spike←0, s←v.
- Output-neuron current cur_out (register, W bits) ← saturating sum over i of (spike_in[i] ? weight[i] : 0). It is computed in W+$clog2(N_IN)+1 bits and clamped to 2^W−1. It is 0 when no input spikes.
- Weights: N_IN × W register file. When wr_en=1 and wr_addr<N_IN, weight[wr_addr]←wr_data at the edge. Writes with wr_addr ≥ N_IN are ignored.
- spike_count: increments by 1 on each edge where spike_output=1 and saturates at 16'hFFFF. cnt_clr takes priority over the increment (count←0).
- Reset (asynchronous, any time, including mid-refractory): all s, r, spike registers, cur_out and spike_count ←0; every weight ←WEIGHT_INIT. All outputs therefore reset to 0.

## Timing
- External current sampled at edge k → spike_in visible after edge k (latency 1).
- spike_in after edge k → cur_out after edge k+1 → earliest spike_output after edge k+2. Minimum end-to-end latency is 3 edges.
- A spike is high for exactly one cycle. With REFRAC=R, the next spike from the same neuron occurs no earlier than R+1 edges later.
- Weight write and spike at the same edge: cur_out uses the old weight, and the new weight applies from the next edge.
- Reset release: the first edge with reset=1 performs a normal update from the zero state.

## Structure
- Shared package lif_pkg holds the saturating-add and leak functions and the default parameter constants.
- One sub-module, lif_neuron_core (parameters W, THRESH, LEAK_SHIFT, REFRAC; ports clk, reset, current, state, spike). It is instantiated N_IN+1 times via generate.
- The top level holds the weight file, the cur_out adder tree and spike_count.

## Test plan
All scenarios use default parameters.
- Leak and threshold: ext_current[0]=100 held from reset → s0 goes 100, 188, then saturates to 255 ≥ THRESH. spike_in[0]=1 after the 3rd edge, then s0=0 for 2 refractory cycles, then integration resumes.
- Routing and latency: neuron 0 spikes alone → cur_out=64 one edge later. The output neuron fires only after cumulative leak-adjusted current reaches 200. Check the earliest spike_output is 2 edges after spike_in.
- Weight saturation: write weights 255, 255, 255, force all three to spike together → cur_out=255, not 765. spike_output follows 1 edge later.
- Write collision: write weight[1]=10 on the same edge that spike_in[1]=1 is sampled → cur_out=64. On the next neuron-1 spike, cur_out=10. A write with wr_addr=3 leaves all weights unchanged.
- Counter: preload spike_count to 16'hFFFE via spikes (or force), two more spikes → holds 16'hFFFF. cnt_clr asserted together with a spike → 0.
- Reset mid-operation: assert reset while neuron 2 is refractory and cur_out≠0 → all outputs 0 immediately and weights return to 64. After release, neuron 2 integrates on the first edge with no residual refractory hold.
